// File: rtl/aes128_req_scheduler.sv
// rtl/aes128_req_scheduler.sv - round-robin scheduler sharing one AES128 core among NREQ requesters
module aes128_req_scheduler #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 iClk,
    input  logic                 iReset_n,
    input  logic [NREQ-1:0]      iReq_valid,
    input  logic [NREQ*128-1:0]  iReq_data,
    input  logic [NREQ*128-1:0]  iReq_key,
    output logic [NREQ-1:0]      oReq_ready,
    output logic [NREQ-1:0]      oRsp_valid,
    output logic [127:0]         oRsp_data,
    output logic                 oRsp_err,
    input  logic [NREQ-1:0]      iRsp_ready,
    output logic                 oCore_start,
    output logic [127:0]         oCore_datain,
    output logic [127:0]         oCore_cipherkey,
    input  logic [127:0]         iCore_dataout,
    input  logic                 iCore_done,
    output logic                 oBusy
);

    localparam int GW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   last_grant, gnt_id, grant;
    logic            grant_found;
    logic [TW-1:0]   timer;
    logic [127:0]    res;
    logic            err;

    // Scan from farthest to nearest so the nearest valid after last_grant wins.
    always_comb begin
        int idx;
        grant       = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (iReq_valid[GW'(idx)]) begin
                grant       = GW'(idx);
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_found) state_nxt = S_START;
            S_START: state_nxt = S_BUSY;
            S_BUSY:  if (iCore_done || timer == TMO_LAST) state_nxt = S_RESP;
            S_RESP:  if (iRsp_ready[gnt_id]) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        oReq_ready = '0;
        oRsp_valid = '0;
        // Gated by reset so the accept path is quiet the moment reset asserts.
        if (state == S_IDLE && grant_found && iReset_n) oReq_ready[grant] = 1'b1;
        if (state == S_RESP) oRsp_valid[gnt_id] = 1'b1;
        oRsp_data   = (state == S_RESP) ? res : 128'h0;
        oRsp_err    = (state == S_RESP) && err;
        oCore_start = (state == S_START);
        oBusy       = (state != S_IDLE);
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state           <= S_IDLE;
            timer           <= '0;
            last_grant      <= GW'(NREQ - 1);
            gnt_id          <= '0;
            res             <= '0;
            err             <= 1'b0;
            oCore_datain    <= '0;
            oCore_cipherkey <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        oCore_datain    <= iReq_data[int'(grant)*128 +: 128];
                        oCore_cipherkey <= iReq_key[int'(grant)*128 +: 128];
                        gnt_id          <= grant;
                    end
                end
                S_START: timer <= '0;
                S_BUSY: begin
                    if (timer != TMO_MAX) timer <= timer + TW'(1);
                    if (iCore_done) begin
                        res <= iCore_dataout;
                        err <= 1'b0;
                    end else if (timer == TMO_LAST) begin
                        res <= '0;
                        err <= 1'b1;
                    end
                end
                S_RESP: if (iRsp_ready[gnt_id]) last_grant <= gnt_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_req_scheduler.sv
// tb/tb_aes128_req_scheduler.sv - directed self-checking bench for aes128_req_scheduler
module tb_aes128_req_scheduler;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2 = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
    localparam logic [127:0] CT3 = 128'hcafef00d_55aa55aa_01020304_a5a5a5a5;

    logic          iClk = 1'b0;
    logic          iReset_n;
    logic [3:0]    iReq_valid;
    logic [511:0]  iReq_data, iReq_key;
    logic [3:0]    oReq_ready, oRsp_valid, iRsp_ready;
    logic [127:0]  oRsp_data, oCore_datain, oCore_cipherkey, iCore_dataout;
    logic          oRsp_err, oCore_start, iCore_done, oBusy;
    logic          model_done, tb_done;
    logic [127:0]  pt_tab [4];
    logic [127:0]  key_tab [4];
    int            model_lat = 0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    assign iCore_done = model_done | tb_done;

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    aes128_req_scheduler #(.NREQ(4), .TIMEOUT_CYC(64)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iReq_valid(iReq_valid), .iReq_data(iReq_data),
        .iReq_key(iReq_key), .oReq_ready(oReq_ready), .oRsp_valid(oRsp_valid),
        .oRsp_data(oRsp_data), .oRsp_err(oRsp_err), .iRsp_ready(iRsp_ready),
        .oCore_start(oCore_start), .oCore_datain(oCore_datain),
        .oCore_cipherkey(oCore_cipherkey), .iCore_dataout(iCore_dataout),
        .iCore_done(iCore_done), .oBusy(oBusy)
    );

    // Core model: pulse done model_lat cycles after the start cycle (0 = never).
    initial begin
        model_done = 1'b0;
        forever begin
            @(posedge iClk);
            if (model_lat > 0 && oCore_start === 1'b1) begin
                repeat (model_lat - 1) @(posedge iClk);
                #1 model_done = 1'b1;
                @(posedge iClk);
                #1 model_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (oRsp_valid === 4'b0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (oBusy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        iReset_n = 1'b0; iReq_valid = '0; iRsp_ready = '0; tb_done = 1'b0;
        iCore_dataout = '0; model_lat = 0;
        repeat (3) tick();
        checks++;
        if (oReq_ready !== 4'b0 || oRsp_valid !== 4'b0 || oRsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: ready=%b rsp_valid=%b err=%b, required 0000 0000 0", oReq_ready, oRsp_valid, oRsp_err);
        end
        checks++;
        if (oRsp_data !== 128'h0 || oCore_datain !== 128'h0 || oCore_cipherkey !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: rsp_data=%h datain=%h key=%h, required all 0", oRsp_data, oCore_datain, oCore_cipherkey);
        end
        checks++;
        if (oCore_start !== 1'b0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: start=%b busy=%b, required 0 0", oCore_start, oBusy);
        end
        iReset_n = 1'b1;
        tick();
    endtask

    task automatic test_fairness();
        int prev = 0;
        int n;
        logic [3:0] exp;
        model_lat = 1; iCore_dataout = CT; iRsp_ready = 4'hF;
        iReq_valid = 4'hF;
        #1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (oReq_ready === 4'b0 && n < 20) begin
                tick();
                n++;
            end
            exp = 4'b0001 << (i % 4);
            checks++;
            if (oReq_ready !== exp) begin
                errors++;
                $display("FAIL fair_grant%0d: ready=%b, required %b", i, oReq_ready, exp);
            end
            if (i > 0) begin
                checks++;
                if (cyc - prev !== 4) begin
                    errors++;
                    $display("FAIL fair_spacing%0d: spacing=%0d cycles, required 4", i, cyc - prev);
                end
            end
            prev = cyc;
            tick();
            if (i == 4) iReq_valid = '0;
            checks++;
            if (oCore_datain !== pt_tab[i % 4] || oCore_cipherkey !== key_tab[i % 4]) begin
                errors++;
                $display("FAIL fair_capture%0d: datain=%h key=%h, required %h %h", i, oCore_datain, oCore_cipherkey, pt_tab[i % 4], key_tab[i % 4]);
            end
        end
        wait_idle();
    endtask

    task automatic test_single_job();
        int t0, n;
        model_lat = 10; iCore_dataout = CT; iRsp_ready = 4'hF;
        iReq_valid = 4'b0001;
        #1;
        checks++;
        if (oReq_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: ready=%b, required 0001", oReq_ready);
        end
        t0 = cyc;
        tick();
        iReq_valid = '0;
        checks++;
        if (oCore_start !== 1'b1 || oBusy !== 1'b1 || oCore_datain !== PT || oCore_cipherkey !== KEY) begin
            errors++;
            $display("FAIL single_start: start=%b busy=%b datain=%h key=%h, required 1 1 %h %h", oCore_start, oBusy, oCore_datain, oCore_cipherkey, PT, KEY);
        end
        tick();
        checks++;
        if (oCore_start !== 1'b0) begin
            errors++;
            $display("FAIL single_start_pulse: start=%b one cycle after start, required 0", oCore_start);
        end
        wait_rsp(n);
        checks++;
        if (cyc - t0 !== 12) begin
            errors++;
            $display("FAIL single_latency: rsp after %0d cycles, required 12", cyc - t0);
        end
        checks++;
        if (oRsp_valid !== 4'b0001 || oRsp_data !== CT || oRsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: valid=%b data=%h err=%b, required 0001 %h 0", oRsp_valid, oRsp_data, oRsp_err, CT);
        end
        tick();
        checks++;
        if (oBusy !== 1'b0 || oRsp_valid !== 4'b0) begin
            errors++;
            $display("FAIL single_release: busy=%b valid=%b, required 0 0000", oBusy, oRsp_valid);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int bad = 0;
        model_lat = 3; iCore_dataout = CT2; iRsp_ready = 4'b0;
        iReq_valid = 4'b0100;
        #1;
        checks++;
        if (oReq_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_ready: ready=%b, required 0100", oReq_ready);
        end
        tick();
        iReq_valid = 4'b0001;
        wait_rsp(n);
        checks++;
        if (oRsp_valid !== 4'b0100 || oRsp_data !== CT2) begin
            errors++;
            $display("FAIL bp_rsp: valid=%b data=%h, required 0100 %h", oRsp_valid, oRsp_data, CT2);
        end
        iRsp_ready = 4'b1011;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (oRsp_valid !== 4'b0100 || oRsp_data !== CT2 || oBusy !== 1'b1 || oReq_ready !== 4'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles of 20, required 0", bad);
        end
        iRsp_ready = 4'b0100;
        tick();
        checks++;
        if (oBusy !== 1'b0 || oReq_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release: busy=%b ready=%b, required 0 0001", oBusy, oReq_ready);
        end
        iReq_valid = '0;
        iRsp_ready = 4'hF;
    endtask

    task automatic test_timeout();
        int t0, n;
        int bad = 0;
        model_lat = 0;
        iReq_valid = 4'b0010;
        #1;
        checks++;
        if (oReq_ready !== 4'b0010) begin
            errors++;
            $display("FAIL tmo_ready: ready=%b, required 0010", oReq_ready);
        end
        t0 = cyc;
        tick();
        iReq_valid = '0;
        wait_rsp(n);
        checks++;
        if (cyc - t0 !== 66) begin
            errors++;
            $display("FAIL tmo_latency: rsp after %0d cycles, required 66", cyc - t0);
        end
        checks++;
        if (oRsp_valid !== 4'b0010 || oRsp_err !== 1'b1 || oRsp_data !== 128'h0) begin
            errors++;
            $display("FAIL tmo_rsp: valid=%b err=%b data=%h, required 0010 1 0", oRsp_valid, oRsp_err, oRsp_data);
        end
        tick();
        iCore_dataout = CT; tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (oRsp_valid !== 4'b0 || oBusy !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tmo_late_done: %0d cycles with response/busy after idle done, required 0", bad);
        end
    endtask

    task automatic test_race();
        int t0, n;
        int bad = 0;
        model_lat = 64; iCore_dataout = CT3;
        iReq_valid = 4'b1000;
        #1;
        checks++;
        if (oReq_ready !== 4'b1000) begin
            errors++;
            $display("FAIL race_ready: ready=%b, required 1000", oReq_ready);
        end
        t0 = cyc;
        tick();
        iReq_valid = '0;
        wait_rsp(n);
        checks++;
        if (cyc - t0 !== 66 || oRsp_valid !== 4'b1000 || oRsp_err !== 1'b0 || oRsp_data !== CT3) begin
            errors++;
            $display("FAIL race_rsp: after %0d valid=%b err=%b data=%h, required 66 1000 0 %h", cyc - t0, oRsp_valid, oRsp_err, oRsp_data, CT3);
        end
        tick();
        model_lat = 0;
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (oRsp_valid !== 4'b0 || oBusy !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL race_spurious: %0d cycles with response/busy after spurious done, required 0", bad);
        end
    endtask

    task automatic test_reset_busy();
        int bad = 0;
        model_lat = 0;
        iReq_valid = 4'b0100;
        #1;
        tick();
        iReq_valid = '0;
        repeat (5) tick();
        checks++;
        if (oBusy !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_pre: busy=%b, required 1", oBusy);
        end
        iReq_valid = 4'hF;
        iReset_n = 1'b0;
        #1;
        checks++;
        if (oBusy !== 1'b0 || oReq_ready !== 4'b0 || oRsp_valid !== 4'b0 || oCore_start !== 1'b0 ||
            oRsp_err !== 1'b0 || oRsp_data !== 128'h0 || oCore_datain !== 128'h0 || oCore_cipherkey !== 128'h0) begin
            errors++;
            $display("FAIL rst_async: busy=%b ready=%b valid=%b start=%b datain=%h, required all 0", oBusy, oReq_ready, oRsp_valid, oCore_start, oCore_datain);
        end
        #1 iReset_n = 1'b1;
        #1;
        checks++;
        if (oReq_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rst_first_grant: ready=%b, required 0001", oReq_ready);
        end
        iReq_valid = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (oRsp_valid !== 4'b0 || oBusy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_stale: %0d cycles with stale response/busy, required 0", bad);
        end
    endtask

    initial begin
        pt_tab[0]  = PT;
        pt_tab[1]  = 128'h11111111_22222222_33333333_44444444;
        pt_tab[2]  = 128'h55555555_66666666_77777777_88888888;
        pt_tab[3]  = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;
        key_tab[0] = KEY;
        key_tab[1] = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        key_tab[2] = 128'hf0f0f0f0_e1e1e1e1_d2d2d2d2_c3c3c3c3;
        key_tab[3] = 128'h13579bdf_2468ace0_fedcba98_76543210;
        for (int i = 0; i < 4; i++) begin
            iReq_data[128*i +: 128] = pt_tab[i];
            iReq_key[128*i +: 128]  = key_tab[i];
        end
        test_reset();
        test_fairness();
        test_single_job();
        test_backpressure();
        test_timeout();
        test_race();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
